// File: rtl/mem_arb_pkg.sv
// Shared types for the two-port main-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_t;

  // 0 = I-cache, 1 = D-cache
  typedef logic req_id_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester handshake and memory-side control bundle of the arbiter.
interface mem_port_arbiter_if;

  logic req0_strobe;
  logic req0_rw;
  logic req1_strobe;
  logic req1_rw;
  logic gnt0;
  logic gnt1;
  logic done0;
  logic done1;
  logic mem_strobe;
  logic mem_rw;
  logic mem_sel;
  logic busy;

  modport slave (
    input  req0_strobe, req0_rw, req1_strobe, req1_rw,
    output gnt0, gnt1, done0, done1, mem_strobe, mem_rw, mem_sel, busy
  );

  modport master (
    output req0_strobe, req0_rw, req1_strobe, req1_rw,
    input  gnt0, gnt1, done0, done1, mem_strobe, mem_rw, mem_sel, busy
  );

endinterface

// File: rtl/mem_wait_ctr.sv
// Loadable down-counter timing memory wait states; last flags the final wait cycle.
module mem_wait_ctr #(
  parameter int unsigned CTR_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ld,
  input  logic [CTR_W-1:0] ld_val,
  input  logic             dec,
  output logic             last
);

  logic [CTR_W-1:0] ctr_q, ctr_d;

  always_comb begin
    ctr_d = ctr_q;
    if (ld) begin
      ctr_d = ld_val;
    end else if (dec) begin
      ctr_d = ctr_q - CTR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ctr_q <= '0;
    end else begin
      ctr_q <= ctr_d;
    end
  end

  assign last = (ctr_q == CTR_W'(1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one main-memory port between I-cache and D-cache.
// Moore FSM: every output decodes from registered state, owner, rw_q and the wait counter.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 4,
  parameter int unsigned CTR_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  mem_port_arbiter_if.slave   bus
);

  arb_state_t state_q, state_d;
  req_id_t    owner_q, owner_d;
  req_id_t    last_q, last_d;
  logic       rw_q, rw_d;
  logic       ctr_ld, ctr_dec, ctr_last;

  mem_wait_ctr #(
    .CTR_W (CTR_W)
  ) u_wait_ctr (
    .clk    (clk),
    .reset  (reset),
    .ld     (ctr_ld),
    .ld_val (CTR_W'(WAIT_STATES)),
    .dec    (ctr_dec),
    .last   (ctr_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rw_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rw_q    <= rw_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    rw_d    = rw_q;
    ctr_ld  = 1'b0;
    ctr_dec = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.req0_strobe || bus.req1_strobe) begin
          // On a tie the requester not served last wins.
          if (bus.req0_strobe && bus.req1_strobe) begin
            owner_d = ~last_q;
          end else begin
            owner_d = bus.req1_strobe;
          end
          rw_d    = owner_d ? bus.req1_rw : bus.req0_rw;
          last_d  = owner_d;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ctr_ld  = 1'b1;
        state_d = (WAIT_STATES > 0) ? WAIT : DONE;
      end
      WAIT: begin
        if (ctr_last) begin
          state_d = DONE;
        end else begin
          ctr_dec = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.gnt0       = bus.busy && (owner_q == 1'b0);
    bus.gnt1       = bus.busy && (owner_q == 1'b1);
    bus.mem_strobe = (state_q == ISSUE);
    bus.done0      = (state_q == DONE) && (owner_q == 1'b0);
    bus.done1      = (state_q == DONE) && (owner_q == 1'b1);
    bus.mem_sel    = bus.busy && owner_q;
    bus.mem_rw     = bus.busy && rw_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one DUT with 4 wait states, one with none.
module tb_mem_port_arbiter;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mem_port_arbiter_if if0 ();
  mem_port_arbiter_if if2 ();

  mem_port_arbiter #(
    .WAIT_STATES (4),
    .CTR_W       (8)
  ) u_dut (
    .clk   (clk),
    .reset (reset),
    .bus   (if0)
  );

  mem_port_arbiter #(
    .WAIT_STATES (0),
    .CTR_W       (8)
  ) u_dut_ws0 (
    .clk   (clk),
    .reset (reset),
    .bus   (if2)
  );

  // {gnt0, gnt1, done0, done1, mem_strobe, mem_rw, mem_sel, busy}
  logic [7:0] obs0, obs2;
  assign obs0 = {if0.gnt0, if0.gnt1, if0.done0, if0.done1,
                 if0.mem_strobe, if0.mem_rw, if0.mem_sel, if0.busy};
  assign obs2 = {if2.gnt0, if2.gnt1, if2.done0, if2.done1,
                 if2.mem_strobe, if2.mem_rw, if2.mem_sel, if2.busy};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs k cycles after the ISSUE cycle of one access (k<0: not yet started).
  function automatic logic [7:0] exp_out(int k, bit own, bit rw, int ws);
    logic [7:0] v;
    v = 8'h00;
    if (k >= 0 && k <= ws + 1) begin
      v[7] = !own;
      v[6] = own;
      v[2] = rw;
      v[1] = own;
      v[0] = 1'b1;
      if (k == 0) v[3] = 1'b1;
      if (k == ws + 1) begin
        v[5] = !own;
        v[4] = own;
      end
    end
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if0.req0_strobe = 1'b0; if0.req0_rw = 1'b0;
    if0.req1_strobe = 1'b0; if0.req1_rw = 1'b0;
    if2.req0_strobe = 1'b0; if2.req0_rw = 1'b0;
    if2.req1_strobe = 1'b0; if2.req1_rw = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    checks++;
    if (obs0 !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs0, 8'h00);
    end
    checks++;
    if (obs2 !== 8'h00) begin
      errors++;
      $display("FAIL reset_outputs_ws0: got %b expected %b", obs2, 8'h00);
    end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_read();
    logic [7:0] exp;
    do_reset();
    if0.req0_strobe = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      tick();
      exp = exp_out(c - 1, 1'b0, 1'b0, 4);
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL single_read c%0d: got %b expected %b", c, obs0, exp);
      end
      if (c == 6) if0.req0_strobe = 1'b0;
    end
  endtask

  task automatic test_tie();
    logic [7:0] exp;
    do_reset();
    if0.req0_strobe = 1'b1;
    if0.req1_strobe = 1'b1;
    if0.req1_rw     = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      tick();
      exp = exp_out(c - 1, 1'b0, 1'b0, 4) | exp_out(c - 8, 1'b1, 1'b1, 4);
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL tie c%0d: got %b expected %b", c, obs0, exp);
      end
      if (c == 6)  if0.req0_strobe = 1'b0;
      if (c == 13) if0.req1_strobe = 1'b0;
    end
    if0.req1_rw = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp;
    do_reset();
    if0.req0_strobe = 1'b1;
    if0.req1_strobe = 1'b1;
    if0.req1_rw     = 1'b1;
    for (int c = 1; c <= 29; c++) begin
      tick();
      exp = 8'h00;
      for (int i = 0; i < 4; i++) begin
        exp = exp | exp_out(c - 1 - 7 * i, i[0], i[0], 4);
      end
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL back_to_back c%0d: got %b expected %b", c, obs0, exp);
      end
      checks++;
      if ((if0.gnt0 && if0.gnt1) !== 1'b0) begin
        errors++;
        $display("FAIL gnt_exclusive c%0d: got gnt0=%b gnt1=%b expected not both",
                 c, if0.gnt0, if0.gnt1);
      end
      if (c == 28) begin
        if0.req0_strobe = 1'b0;
        if0.req1_strobe = 1'b0;
      end
    end
    if0.req1_rw = 1'b0;
  endtask

  task automatic test_zero_wait();
    logic [7:0] exp;
    do_reset();
    if2.req1_strobe = 1'b1;
    if2.req1_rw     = 1'b1;
    for (int c = 1; c <= 3; c++) begin
      tick();
      exp = exp_out(c - 1, 1'b1, 1'b1, 0);
      checks++;
      if (obs2 !== exp) begin
        errors++;
        $display("FAIL zero_wait c%0d: got %b expected %b", c, obs2, exp);
      end
      if (c == 2) if2.req1_strobe = 1'b0;
    end
    if2.req1_rw = 1'b0;
  endtask

  task automatic test_reset_mid_access();
    logic [7:0] exp;
    do_reset();
    if0.req1_strobe = 1'b1;
    if0.req1_rw     = 1'b1;
    for (int c = 1; c <= 3; c++) tick();
    checks++;
    if (obs0 !== exp_out(2, 1'b1, 1'b1, 4)) begin
      errors++;
      $display("FAIL pre_abort_wait: got %b expected %b", obs0, exp_out(2, 1'b1, 1'b1, 4));
    end
    reset = 1'b1;
    tick();
    checks++;
    if (obs0 !== 8'h00) begin
      errors++;
      $display("FAIL abort_outputs: got %b expected %b", obs0, 8'h00);
    end
    reset = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      tick();
      exp = exp_out(c - 1, 1'b1, 1'b1, 4);
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL after_abort c%0d: got %b expected %b", c, obs0, exp);
      end
      if (c == 6) if0.req1_strobe = 1'b0;
    end
    if0.req1_rw = 1'b0;
  endtask

  task automatic test_drop_mid_access();
    logic [7:0] exp;
    do_reset();
    if0.req0_strobe = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick();
      exp = exp_out(c - 1, 1'b0, 1'b0, 4);
      checks++;
      if (obs0 !== exp) begin
        errors++;
        $display("FAIL drop_mid c%0d: got %b expected %b", c, obs0, exp);
      end
      if (c == 3) if0.req0_strobe = 1'b0;
      if (c >= 3) if0.req0_rw = ~if0.req0_rw;
    end
    if0.req0_rw = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    clear_inputs();
    test_reset();
    test_single_read();
    test_tie();
    test_back_to_back();
    test_zero_wait();
    test_reset_mid_access();
    test_drop_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
